// File: rtl/instruction_fetch_controller.sv
//------------------------------------------------------------------------------
// Module      : instruction_fetch_controller
// Description : Sequences instruction fetch. Requests a word from program
//               memory at the PC, strobes it into the instruction register,
//               holds it valid for execute until completion, then advances
//               the PC (increment or branch).
// Options     : FETCH_TIMEOUT_EN - when defined, a watchdog counts
//               consecutive unacknowledged FETCH cycles and enters a sticky
//               error state after TIMEOUT_CYCLES of them.
// Ports       : clk, reset                  - clock, sync active-high reset
//               mem_req/mem_addr            - fetch request and address
//               mem_ack/mem_rdata           - memory data valid and word
//               ir_load/ir_data             - instruction register load/data
//               instr_valid                 - instruction held for execute
//               exec_done/branch_taken/
//               branch_target               - execute completion and branch
//               halt                        - stop fetching
//               pc, busy, fetch_error       - status
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instruction_fetch_controller #(
  parameter int ADDR_W         = 8,
  parameter int INSTR_W        = 15,
  parameter int RESET_PC       = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               ir_load,
  output logic [INSTR_W-1:0] ir_data,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               fetch_error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
`else
  // Watchdog limit has no effect in this build.
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef FETCH_TIMEOUT_EN
    wd_d    = '0;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = halt ? S_HALTED : S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = S_LOAD;
        end
`ifdef FETCH_TIMEOUT_EN
        // Trip on the TIMEOUT_CYCLES-th consecutive cycle without an ack.
        else if (wd_q == WD_LAST) begin
          state_d = S_ERR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_LOAD: begin
        pc_d    = pc_q + 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) begin
          if (branch_taken) begin
            pc_d = branch_target;
          end
          state_d = halt ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: begin
        if (!halt) begin
          state_d = S_FETCH;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
      ir_q    <= '0;
`ifdef FETCH_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
`ifdef FETCH_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  // All control outputs decode straight from the registered state, so a
  // reset edge removes every request/strobe in the following cycle.
  assign mem_req     = (state_q == S_FETCH);
  assign mem_addr    = pc_q;
  assign ir_load     = (state_q == S_LOAD);
  assign ir_data     = ir_q;
  assign instr_valid = (state_q == S_EXEC);
  assign pc          = pc_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                       (state_q == S_EXEC);

`ifdef FETCH_TIMEOUT_EN
  assign fetch_error = (state_q == S_ERR);
`else
  assign fetch_error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_controller.sv
//------------------------------------------------------------------------------
// Module      : tb_instruction_fetch_controller
// Description : Directed self-checking bench for instruction_fetch_controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instruction_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [14:0] mem_rdata;
  logic        ir_load;
  logic [14:0] ir_data;
  logic        instr_valid;
  logic        exec_done;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        halt;
  logic [7:0]  pc;
  logic        busy;
  logic        fetch_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instruction_fetch_controller #(
    .ADDR_W(8), .INSTR_W(15), .RESET_PC(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_load(ir_load), .ir_data(ir_data),
    .instr_valid(instr_valid),
    .exec_done(exec_done), .branch_taken(branch_taken),
    .branch_target(branch_target),
    .halt(halt), .pc(pc), .busy(busy), .fetch_error(fetch_error)
  );

  // Advance one clock; outputs are looked at and inputs changed 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0; exec_done = 1'b0;
    branch_taken = 1'b0; branch_target = '0; halt = 1'b0;
    step(); step();

    // Reset state
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_ir_data", 32'(ir_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ir_load", 32'(ir_load), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_fetch_error", 32'(fetch_error), 32'd0);

    // 1: zero-wait ack
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 15'h1234;
    step();
    chk("t1_mem_req", 32'(mem_req), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h00);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_no_ir_load_in_fetch", 32'(ir_load), 32'd0);
    step();
    mem_ack = 1'b0; mem_rdata = 15'h7FFF;
    chk("t1_ir_load", 32'(ir_load), 32'd1);
    chk("t1_ir_data", 32'(ir_data), 32'h1234);
    chk("t1_mem_req_load", 32'(mem_req), 32'd0);
    step();
    chk("t1_ir_load_pulse", 32'(ir_load), 32'd0);
    chk("t1_pc", 32'(pc), 32'h01);
    chk("t1_instr_valid", 32'(instr_valid), 32'd1);
    chk("t1_ir_data_exec", 32'(ir_data), 32'h1234);
    step();
    chk("t1_hold_valid", 32'(instr_valid), 32'd1);
    chk("t1_hold_ir", 32'(ir_data), 32'h1234);

    // 2: ack delayed 3 cycles; halt inside FETCH must not abort
    exec_done = 1'b1;
    step();
    exec_done = 1'b0; halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_mem_req", 32'(mem_req), 32'd1);
      chk("t2_mem_addr", 32'(mem_addr), 32'h01);
      chk("t2_no_ir_load", 32'(ir_load), 32'd0);
      if (i == 3) begin
        mem_ack = 1'b1; mem_rdata = 15'h0ABC; halt = 1'b0;
      end
      if (i < 3) step();
    end
    step();
    mem_ack = 1'b0;
    chk("t2_ir_load", 32'(ir_load), 32'd1);
    chk("t2_ir_data", 32'(ir_data), 32'h0ABC);
    step();
    chk("t2_pc", 32'(pc), 32'h02);

    // 3: branch taken, then plain increment
    exec_done = 1'b1; branch_taken = 1'b1; branch_target = 8'h40;
    step();
    exec_done = 1'b0; branch_taken = 1'b0; mem_ack = 1'b1; mem_rdata = 15'h0111;
    chk("t3_branch_addr", 32'(mem_addr), 32'h40);
    step();
    mem_ack = 1'b0;
    step();
    chk("t3_pc_after_branch", 32'(pc), 32'h41);
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    chk("t3_inc_addr", 32'(mem_addr), 32'h41);
    chk("t3_inc_req", 32'(mem_req), 32'd1);

    // 4: wrap at 0xFF
    mem_ack = 1'b1; mem_rdata = 15'h0222;
    step(); mem_ack = 1'b0;
    step();
    exec_done = 1'b1; branch_taken = 1'b1; branch_target = 8'hFF;
    step();
    exec_done = 1'b0; branch_taken = 1'b0;
    chk("t4_addr_ff", 32'(mem_addr), 32'hFF);
    mem_ack = 1'b1; mem_rdata = 15'h0333;
    step(); mem_ack = 1'b0;
    chk("t4_pc_during_load", 32'(pc), 32'hFF);
    step();
    chk("t4_pc_wrap", 32'(pc), 32'h00);

    // 5: halt on exec_done, resume at held pc
    exec_done = 1'b1; halt = 1'b1;
    step();
    exec_done = 1'b0;
    chk("t5_halt_req", 32'(mem_req), 32'd0);
    chk("t5_halt_busy", 32'(busy), 32'd0);
    chk("t5_halt_valid", 32'(instr_valid), 32'd0);
    mem_ack = 1'b1;  // ignored outside FETCH
    step();
    mem_ack = 1'b0;
    chk("t5_still_halted", 32'(mem_req), 32'd0);
    chk("t5_pc_held", 32'(pc), 32'h00);
    halt = 1'b0;
    step();
    chk("t5_resume_req", 32'(mem_req), 32'd1);
    chk("t5_resume_addr", 32'(mem_addr), 32'h00);

    // Reset mid-operation: advance pc then reset during FETCH
    mem_ack = 1'b1; mem_rdata = 15'h0444;
    step(); mem_ack = 1'b0;
    step();
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    chk("rm_fetch_addr", 32'(mem_addr), 32'h01);
    reset = 1'b1;
    step();
    chk("rm_req_low", 32'(mem_req), 32'd0);
    chk("rm_pc", 32'(pc), 32'h00);
    chk("rm_ir_data", 32'(ir_data), 32'h0);
    reset = 1'b0;
    step();
    chk("rm_restart_addr", 32'(mem_addr), 32'h00);
    chk("rm_restart_req", 32'(mem_req), 32'd1);

`ifdef FETCH_TIMEOUT_EN
    // 6: watchdog, ack never arrives; 16 FETCH cycles then ERR
    for (int i = 1; i < 16; i++) begin
      step();
      chk("t6_no_err_yet", 32'(fetch_error), 32'd0);
    end
    step();
    chk("t6_fetch_error", 32'(fetch_error), 32'd1);
    chk("t6_err_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b1;
    step(); step();
    mem_ack = 1'b0;
    chk("t6_sticky", 32'(fetch_error), 32'd1);
    reset = 1'b1;
    step();
    chk("t6_reset_clears", 32'(fetch_error), 32'd0);
    reset = 1'b0;
    step();
    chk("t6_restart_addr", 32'(mem_addr), 32'h00);
    chk("t6_restart_req", 32'(mem_req), 32'd1);
`else
    // Without the watchdog, FETCH waits indefinitely.
    for (int i = 0; i < 20; i++) step();
    chk("t6_no_watchdog_req", 32'(mem_req), 32'd1);
    chk("t6_no_watchdog_err", 32'(fetch_error), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
